ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Keyboard front end for the game controller. It receives raw PS/2 frames from the keyboard pins and decodes scan-code set 2 make/break sequences. It drives level-held key signals (A, D, W, S, J, K, L, SPACE) to the movement/stage controller, which consumes them as "key currently held" inputs. The block is the producer side of that key-signal interface.

## Interface
- `TIMEOUT_CYCLES`, 200000: clk cycles with no PS/2 falling edge before a partial frame is discarded (2 ms at 100 MHz).
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous to `clk`.
- `A_signal`, `D_signal`, `W_signal`, `S_signal`, `J_signal`, `K_signal`, `L_signal`, `SPACE_signal`  out  1 each  high while the key is held.
- `scancode`  out  8  last validly received byte.
- `scancode_valid`  out  1  one-cycle strobe; `scancode` is new.
- `frame_err`  out  1  one-cycle strobe on a bad or timed-out frame.

## Operation
- Reset (`rst`=0, async): all outputs 0, bit counter 0, decode FSM in IDLE, synchronizers reset to 1 (idle bus level).
- Input path: `ps2_clk` and `ps2_data` each pass through 2 synchronizer flops. A third flop on the clock path provides edge detection. A falling-edge strobe fires when the previous synced value is 1 and the current one is 0.
- Frame receive: on each strobe, shift the synced data into an 11-bit register and increment the bit counter 0..10. Bit order: start(0), D0..D7 LSB first, odd parity, stop(1).
- On the 11th bit, the frame is good if start=0, stop=1, and parity is odd. A good frame loads `scancode` and pulses `scancode_valid`. A bad frame pulses `frame_err`. In both cases the counter returns to 0.
- Timeout: if the counter ≠ 0 and `TIMEOUT_CYCLES` elapse with no strobe, the counter clears and `frame_err` pulses. The timeout counter resets on every strobe and saturates.
- Decode FSM, advanced only on `scancode_valid`:
  - IDLE: byte F0 → BREAK. Byte E0 → EXT. Mapped code → set that key to 1, stay in IDLE. Any other byte (including AA, FA, EE) → ignored.
  - BREAK: mapped code → clear that key to 0. Any byte → IDLE.
  - EXT: byte F0 → EXT_BREAK. Any other byte → IDLE, no key change.
  - EXT_BREAK: any byte → IDLE, no key change. Extended keys never alias onto mapped keys.
- Key map (set 2): A=1C, D=23, W=1D, S=1B, J=3B, K=42, L=4B, SPACE=29.
- Typematic repeat makes of a held key leave it at 1. Each key is independent; multiple keys may be held simultaneously.
- Bad frames do not advance the decode FSM.

## Timing
- A `ps2_clk` pin fall is seen as a strobe 3 clk later (2 sync flops plus the edge flop). Data is sampled from the synced data at the same cycle.
- `scancode_valid` and `scancode` are registered 1 clk after the 11th strobe.
- A key output changes 1 clk after the `scancode_valid` that completes its make or break sequence.
- A strobe and a timeout in the same cycle: the strobe wins and the timeout counter clears.
- Reset asserted mid-frame: the partial frame is lost and keys drop to 0 immediately.
- Only the PS/2 receive direction is implemented. `ps2_clk` and `ps2_data` are never driven.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: the parity bit is checked as above. A parity mismatch gives `frame_err` and the byte is dropped.
- `PS2_PARITY_CHECK_EN` undefined: the parity bit is ignored. Only start=0 and stop=1 qualify a frame.

## Test plan
- Send frame 1C (parity 0) → `scancode`=1C, `scancode_valid` 1-cycle pulse, `A_signal`=1 one clk later, all other keys 0.
- With A held, send F0 then 1C → `A_signal` returns to 0 after the 1C `scancode_valid`. A sequence 1D, 23 gives `W_signal`=`D_signal`=1 together.
- Send E0,1D then E0,F0,1D → `W_signal` stays 0 throughout and the FSM ends in IDLE. A following 29 gives `SPACE_signal`=1.
- Send 1C with the parity bit flipped → with the macro: `frame_err` pulse, no valid strobe, `A_signal`=0. Without the macro: `A_signal`=1.
- Send 5 bits, then stall for `TIMEOUT_CYCLES` → `frame_err` pulse and counter at 0. A following full 29 frame decodes correctly.
- Assert `rst`=0 with keys held and mid-frame → all outputs 0 asynchronously. After release, a fresh 42 frame gives `K_signal`=1.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and scan-code set 2 decoder producing level-held key signals.
// Optional parity qualification: define PS2_PARITY_CHECK_EN.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       A_signal,
  output logic       D_signal,
  output logic       W_signal,
  output logic       S_signal,
  output logic       J_signal,
  output logic       K_signal,
  output logic       L_signal,
  output logic       SPACE_signal,
  output logic [7:0] scancode,
  output logic       scancode_valid,
  output logic       frame_err
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} dec_state_t;

  // Key vector order: {SPACE, L, K, J, S, W, D, A}
  function automatic logic [7:0] key_map(input logic [7:0] code);
    case (code)
      8'h1C:   key_map = 8'b0000_0001;
      8'h23:   key_map = 8'b0000_0010;
      8'h1D:   key_map = 8'b0000_0100;
      8'h1B:   key_map = 8'b0000_1000;
      8'h3B:   key_map = 8'b0001_0000;
      8'h42:   key_map = 8'b0010_0000;
      8'h4B:   key_map = 8'b0100_0000;
      8'h29:   key_map = 8'b1000_0000;
      default: key_map = 8'b0000_0000;
    endcase
  endfunction

  logic        clk_s1, clk_s2, clk_s3;
  logic        data_s1, data_s2;
  logic        fall;
  logic [10:0] shift_q;
  logic [10:0] frame_next;
  logic [3:0]  bit_cnt;
  logic [TO_W-1:0] to_cnt;
  logic        frame_ok;
  logic        par_ok;
  logic        timeout_hit;

  // Synchronizers idle at the released-bus level so reset never fakes a falling edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {clk_s1, clk_s2, clk_s3} <= 3'b111;
      {data_s1, data_s2}       <= 2'b11;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  assign fall       = clk_s3 & ~clk_s2;
  assign frame_next = {data_s2, shift_q[10:1]};

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = ^frame_next[9:1];
`else
  assign par_ok = 1'b1;
`endif

  assign frame_ok    = ~frame_next[0] & frame_next[10] & par_ok;
  assign timeout_hit = (bit_cnt != 4'd0) && !fall && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q        <= '0;
      bit_cnt        <= '0;
      to_cnt         <= '0;
      scancode       <= '0;
      scancode_valid <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      scancode_valid <= 1'b0;
      frame_err      <= 1'b0;
      if (fall) begin
        shift_q <= frame_next;
        to_cnt  <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (frame_ok) begin
            scancode       <= frame_next[8:1];
            scancode_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (timeout_hit) begin
        bit_cnt   <= '0;
        to_cnt    <= '0;
        frame_err <= 1'b1;
      end else if (bit_cnt == 4'd0) begin
        to_cnt <= '0;
      end else if (to_cnt != TO_LAST) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  dec_state_t state_q, state_d;
  logic [7:0] keys_q, keys_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    keys_d  = keys_q;
    if (scancode_valid) begin
      case (state_q)
        IDLE: begin
          if (scancode == 8'hF0)      state_d = BREAK;
          else if (scancode == 8'hE0) state_d = EXT;
          else                        keys_d  = keys_q | key_map(scancode);
        end
        BREAK: begin
          keys_d  = keys_q & ~key_map(scancode);
          state_d = IDLE;
        end
        EXT:       state_d = (scancode == 8'hF0) ? EXT_BREAK : IDLE;
        EXT_BREAK: state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      keys_q  <= '0;
    end else begin
      state_q <= state_d;
      keys_q  <= keys_d;
    end
  end

  assign {SPACE_signal, L_signal, K_signal, J_signal,
          S_signal, W_signal, D_signal, A_signal} = keys_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus randomized frames
// checked against a byte-sequence model of the make/break protocol.
module tb_ps2_key_decoder;

  localparam int TO = 64;

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       A_signal, D_signal, W_signal, S_signal;
  logic       J_signal, K_signal, L_signal, SPACE_signal;
  logic [7:0] scancode;
  logic       scancode_valid;
  logic       frame_err;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .A_signal(A_signal), .D_signal(D_signal), .W_signal(W_signal), .S_signal(S_signal),
    .J_signal(J_signal), .K_signal(K_signal), .L_signal(L_signal), .SPACE_signal(SPACE_signal),
    .scancode(scancode), .scancode_valid(scancode_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  wire [7:0] keys = {SPACE_signal, L_signal, K_signal, J_signal,
                     S_signal, W_signal, D_signal, A_signal};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: keys change once a full make, break or extended sequence of bytes is seen.
  logic [7:0] exp_q[$];
  int         exp_errs = 0;
  logic [7:0] seq[$];
  logic [7:0] model_keys = '0;

  function automatic logic [7:0] key_bit(input logic [7:0] b);
    case (b)
      8'h1C: return 8'h01;
      8'h23: return 8'h02;
      8'h1D: return 8'h04;
      8'h1B: return 8'h08;
      8'h3B: return 8'h10;
      8'h42: return 8'h20;
      8'h4B: return 8'h40;
      8'h29: return 8'h80;
      default: return 8'h00;
    endcase
  endfunction

  task automatic apply_byte(input logic [7:0] b);
    seq.push_back(b);
    if (seq.size() == 1 && (b == 8'hF0 || b == 8'hE0)) return;
    if (seq.size() == 2 && seq[0] == 8'hE0 && b == 8'hF0) return;
    if (seq.size() == 1)          model_keys = model_keys | key_bit(b);
    else if (seq[0] == 8'hF0)     model_keys = model_keys & ~key_bit(b);
    seq.delete();
  endtask

  // Compare process: outputs are checked against the model every cycle out of reset.
  always @(negedge clk) begin
    if (rst) begin
      check("keys", {24'd0, keys}, {24'd0, model_keys});
      if (scancode_valid && frame_err) check("valid_and_err", 32'd1, 32'd0);
      if (frame_err) begin
        check("unexpected_err", {31'd0, exp_errs > 0}, 32'd1);
        if (exp_errs > 0) exp_errs--;
      end
      if (scancode_valid) begin
        check("unexpected_valid", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("scancode", {24'd0, scancode}, {24'd0, e});
          apply_byte(e);
        end
      end
    end
  end

  task automatic send_bits(input logic [10:0] f, input int n, input int h);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      #(h);
      ps2_clk = 1'b0;
      #(h);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100 && (exp_q.size() != 0 || exp_errs != 0); k++) @(negedge clk);
    check("frame_drain", {31'd0, (exp_q.size() == 0 && exp_errs == 0)}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // kind: 0 good, 1 bad start, 2 bad stop, 3 bad parity
  task automatic send_frame(input logic [7:0] b, input int kind, input int h);
    logic [10:0] f;
    logic par;
    par = ~^b;
    f = {(kind == 2) ? 1'b0 : 1'b1, (kind == 3) ? ~par : par, b, (kind == 1) ? 1'b1 : 1'b0};
    if (kind == 0 || (kind == 3 && !PARITY_EN)) exp_q.push_back(b);
    else exp_errs++;
    send_bits(f, 11, h);
    ps2_data = 1'b1;
    #(2 * h);
    wait_drain();
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 0, 50);
  endtask

  logic [7:0] pool[15] = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h3B, 8'h42, 8'h4B, 8'h29,
                          8'hF0, 8'hF0, 8'hE0, 8'hAA, 8'hFA, 8'h12, 8'h75};

  initial begin
    #800us;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    #23 rst = 1'b1;
    @(negedge clk);
    check("reset_keys", {24'd0, keys}, 32'h0);
    check("reset_scancode", {24'd0, scancode}, 32'h0);
    check("reset_strobes", {30'd0, scancode_valid, frame_err}, 32'h0);

    send_good(8'h1C);
    check("A_make_scancode", {24'd0, scancode}, 32'h1C);
    check("A_make_keys", {24'd0, keys}, 32'h01);
    send_good(8'hF0);
    send_good(8'h1C);
    check("A_break_keys", {24'd0, keys}, 32'h00);
    send_good(8'h1D);
    send_good(8'h23);
    check("W_D_held", {24'd0, keys}, 32'h06);
    send_good(8'hF0); send_good(8'h1D);
    send_good(8'hF0); send_good(8'h23);
    check("W_D_released", {24'd0, keys}, 32'h00);

    send_good(8'hE0); send_good(8'h1D);
    check("ext_make_no_W", {24'd0, keys}, 32'h00);
    send_good(8'hE0); send_good(8'hF0); send_good(8'h1D);
    check("ext_break_no_W", {24'd0, keys}, 32'h00);
    send_good(8'h29);
    check("space_after_ext", {24'd0, keys}, 32'h80);

    send_frame(8'h1C, 3, 50);
    check("parity_flip", {24'd0, keys}, PARITY_EN ? 32'h80 : 32'h81);
    if (!PARITY_EN) begin
      send_good(8'hF0); send_good(8'h1C);
    end
    send_good(8'hF0); send_good(8'h29);
    check("all_released", {24'd0, keys}, 32'h00);

    // Partial frame followed by a stall longer than the timeout.
    exp_errs = 1;
    send_bits(11'b110_0011_1000, 5, 50);
    ps2_data = 1'b1;
    repeat (TO - 12) @(negedge clk);
    check("no_early_timeout", exp_errs, 32'd1);
    repeat (30) @(negedge clk);
    check("timeout_err", exp_errs, 32'd0);
    send_good(8'h29);
    check("space_after_timeout", {24'd0, keys}, 32'h80);
    send_good(8'hF0); send_good(8'h29);

    for (int i = 0; i < 120; i++) begin
      int kind;
      kind = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      send_frame(pool[$urandom_range(0, 14)], kind, int'($urandom_range(40, 95)));
    end

    // Known state, then reset in the middle of a frame with keys held.
    send_good(8'hAA);
    send_good(8'h1C);
    send_good(8'h4B);
    check("keys_before_reset", {24'd0, keys & 8'h41}, 32'h41);
    send_bits(11'b100_0010_1000, 4, 50);
    #3 rst = 1'b0;
    #1;
    check("async_reset_keys", {24'd0, keys}, 32'h0);
    check("async_reset_outs", {22'd0, scancode, scancode_valid, frame_err}, 32'h0);
    model_keys = '0;
    seq.delete();
    exp_q.delete();
    exp_errs = 0;
    ps2_data = 1'b1;
    ps2_clk  = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    send_good(8'h42);
    check("K_after_reset", {24'd0, keys}, 32'h20);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
